fixed_point_mul: RTL and testbench

//  Signed Q4.4 x Q4.4 approximate multiplier ("Approx-T") with run-time selectable accuracy.

---
 rtl/fixed_point_mul.sv | 86 ++++++++
 tb/tb_fixed_point_mul.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fixed_point_mul.sv
// Signed Q4.4 x Q4.4 approximate multiplier with a Q12.4 registered result.
// Each level splits the operand pair at its leading ones; mask bits add back the levels they enable.
module fixed_point_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [5:0]  Conf_Bit_Mask,
  output logic [15:0] R
);

  function automatic logic [2:0] lead_one(input logic [7:0] v);
    lead_one = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) lead_one = 3'(i);
    end
  endfunction

  logic        w_sign;
  logic [7:0]  w_mag_a;
  logic [7:0]  w_mag_b;
  logic [7:0]  w_res_a [0:6];
  logic [7:0]  w_res_b [0:6];
  logic [14:0] w_term  [0:6];
  logic [14:0] w_sum   [0:6];
  logic [15:0] w_scaled;
  logic [15:0] w_result;
  logic [15:0] r_prod;

  assign w_sign  = A[7] ^ B[7];
  // An 8-bit magnitude is enough: negating -128 yields 8'h80 = 128.
  assign w_mag_a = A[7] ? 8'(~A + 8'd1) : A;
  assign w_mag_b = B[7] ? 8'(~B + 8'd1) : B;

  assign w_res_a[0] = w_mag_a;
  assign w_res_b[0] = w_mag_b;

  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_level
      logic [2:0] w_ka;
      logic [2:0] w_kb;
      logic [7:0] w_ra;
      logic [7:0] w_rb;
      logic       w_zero;

      assign w_ka   = lead_one(w_res_a[gi]);
      assign w_kb   = lead_one(w_res_b[gi]);
      // Clearing the lowest... no: v & (v-1) clears the lowest set bit, so use subtraction of 2^k.
      assign w_ra   = w_res_a[gi] - (8'd1 << w_ka);
      assign w_rb   = w_res_b[gi] - (8'd1 << w_kb);
      assign w_zero = (w_res_a[gi] == 8'd0) || (w_res_b[gi] == 8'd0);

      // Term = a*b - ra*rb, built from one power of two and two shifted residuals.
      assign w_term[gi] = w_zero ? 15'd0
                        : (15'd1 << ({1'b0, w_ka} + {1'b0, w_kb}))
                        + (15'(w_ra) << w_kb)
                        + (15'(w_rb) << w_ka);

      if (gi < 6) begin : g_next
        assign w_res_a[gi+1] = w_zero ? 8'd0 : w_ra;
        assign w_res_b[gi+1] = w_zero ? 8'd0 : w_rb;
      end

      if (gi == 0) begin : g_base
        assign w_sum[gi] = w_term[gi];
      end else begin : g_acc
        assign w_sum[gi] = w_sum[gi-1] + (Conf_Bit_Mask[gi-1] ? w_term[gi] : 15'd0);
      end
    end
  endgenerate

  // Truncate the magnitude before applying the sign so rounding is toward zero.
  assign w_scaled = 16'(w_sum[6] >> 4);
  assign w_result = w_sign ? (16'd0 - w_scaled) : w_scaled;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod <= 16'd0;
    end else begin
      r_prod <= w_result;
    end
  end

  assign R = r_prod;

endmodule

// File: tb/tb_fixed_point_mul.sv
// Scoreboard bench for fixed_point_mul: directed cases, strided sweeps and random masks.
module tb_fixed_point_mul;

  logic        clk;
  logic        rst;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [5:0]  Conf_Bit_Mask;
  logic [15:0] R;

  fixed_point_mul dut (
    .clk           (clk),
    .rst           (rst),
    .A             (A),
    .B             (B),
    .Conf_Bit_Mask (Conf_Bit_Mask),
    .R             (R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    exp;
    bit    bnd;
    int    exact;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sext8(input int v);
    logic [7:0] t;
    t = 8'(v);
    return int'($signed(t));
  endfunction

  // Reference: full product minus the (x*y - x'*y') terms of disabled levels,
  // where x' is x with its leading one removed.
  function automatic int model(input int a, input int b, input logic [5:0] m);
    int sa, sb, x, y, nx, ny, p, term, mag;
    sa = sext8(a);
    sb = sext8(b);
    x = (sa < 0) ? -sa : sa;
    y = (sb < 0) ? -sb : sb;
    p = x * y;
    for (int n = 0; n < 7; n++) begin
      nx = 0;
      ny = 0;
      for (int k = 0; k < 8; k++) if (x >= (1 << k)) nx = x - (1 << k);
      for (int k = 0; k < 8; k++) if (y >= (1 << k)) ny = y - (1 << k);
      if (x == 0 || y == 0) begin
        nx = 0;
        ny = 0;
      end
      term = x * y - nx * ny;
      if (n > 0 && !m[n-1]) p -= term;
      x = nx;
      y = ny;
    end
    mag = p >> 4;
    return ((sa < 0) != (sb < 0)) ? -mag : mag;
  endfunction

  function automatic int exact_res(input int a, input int b);
    int sa, sb, mag;
    sa = sext8(a);
    sb = sext8(b);
    mag = (((sa < 0) ? -sa : sa) * ((sb < 0) ? -sb : sb)) >> 4;
    return ((sa < 0) != (sb < 0)) ? -mag : mag;
  endfunction

  task automatic send(input string tag, input bit r, input int a, input int b,
                      input logic [5:0] m, input int exp, input bit bnd);
    sb_item_t it;
    @(negedge clk);
    rst = r;
    A = 8'(a);
    B = 8'(b);
    Conf_Bit_Mask = m;
    it.tag = tag;
    it.exp = exp;
    it.bnd = bnd;
    it.exact = exact_res(a, b);
    sb_q.push_back(it);
  endtask

  always @(posedge clk) begin
    sb_item_t e;
    int obs;
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      obs = int'($signed(R));
      check_val(e.tag, obs, e.exp);
      if (e.bnd) begin
        check_val({e.tag, "_bound"},
                  int'(((obs < 0) ? -obs : obs) <= ((e.exact < 0) ? -e.exact : e.exact)), 1);
      end
    end
  end

  initial begin
    int b;
    rst = 1'b1;
    A = 8'h00;
    B = 8'h00;
    Conf_Bit_Mask = 6'b0;

    send("reset",      1'b1, 8'h7F, 8'h7F, 6'b111111, 0, 1'b0);
    send("post_reset", 1'b0, 8'h7F, 8'h7F, 6'b111111, 1008, 1'b0);
    send("one_x_one",  1'b0, 16, 16, 6'b000000, 16, 1'b0);
    send("one_x_neg",  1'b0, 16, -16, 6'b000000, -16, 1'b0);
    send("max_m0",     1'b0, 127, 127, 6'b000000, 760, 1'b0);
    send("max_m63",    1'b0, 127, 127, 6'b111111, 1008, 1'b0);
    send("n3x2p5_m0",  1'b0, -48, 40, 6'b000000, -112, 1'b0);
    send("n3x2p5_m1",  1'b0, -48, 40, 6'b000001, -120, 1'b0);
    send("min_x_min",  1'b0, -128, -128, 6'b111111, 1024, 1'b0);
    send("zero_a",     1'b0, 0, -77, 6'b101010, 0, 1'b0);
    send("zero_b",     1'b0, -1, 0, 6'b111111, 0, 1'b0);
    send("mid_rst",    1'b1, 100, 100, 6'b111111, 0, 1'b0);
    send("rst_exit",   1'b0, 100, 100, 6'b111111, exact_res(100, 100), 1'b0);

    for (int a = 0; a < 256; a++) begin
      for (int j = 0; j < 64; j++) begin
        b = j * 4 + (a & 3);
        send("sweep_full", 1'b0, a, b, 6'b111111, exact_res(a, b), 1'b0);
      end
    end
    for (int a = 0; a < 256; a++) begin
      for (int j = 0; j < 64; j++) begin
        b = j * 4 + ((a + 1) & 3);
        send("sweep_m0", 1'b0, a, b, 6'b000000, model(a, b, 6'b000000), 1'b1);
      end
    end
    for (int i = 0; i < 3000; i++) begin
      int ra, rb;
      logic [5:0] rm;
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      rm = 6'($urandom_range(0, 63));
      send("rand_mask", 1'b0, ra, rb, rm, model(ra, rb, rm), 1'b1);
    end

    @(negedge clk);
    @(negedge clk);
    check_val("drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
